// File: rtl/word_serialiser.sv
// Parallel-to-serial word converter: emits one bit per beat, LSB first
// (store order) by default or MSB first when msb_first is set at acceptance.
module word_serialiser #(
  parameter int WORD_WIDTH = 32,
  parameter int BEAT_DIV   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  input  logic                  msb_first,
  input  logic                  abort,
  output logic                  ser_bit,
  output logic                  ser_valid,
  output logic                  ser_first,
  output logic                  ser_last,
  output logic                  busy
);

  localparam int                BEAT_W       = $clog2(WORD_WIDTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT    = BEAT_W'(WORD_WIDTH - 1);
  localparam logic [BEAT_W-1:0] PENULT_BEAT  = BEAT_W'(WORD_WIDTH - 2);
  localparam logic [7:0]        LAST_DIV     = 8'(BEAT_DIV - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state_r;
  logic [WORD_WIDTH-1:0] shift_r;
  logic                  order_r;
  logic [BEAT_W-1:0]     beat_r;
  logic [7:0]            div_r;

  logic beat_end_s;
  logic final_s;
  logic accept_s;

  // The bit presented first is taken straight from the incoming word so that
  // beat 0 is valid on the cycle right after acceptance.
  function automatic logic first_bit(input logic [WORD_WIDTH-1:0] w, input logic msb);
    return msb ? w[WORD_WIDTH-1] : w[0];
  endfunction

  assign beat_end_s = (div_r == LAST_DIV);
  assign final_s    = (state_r == SHIFT) && beat_end_s && (beat_r == LAST_BEAT);
  assign word_ready = !abort && reset_n && ((state_r == IDLE) || final_s);
  assign accept_s   = word_valid && word_ready;

  // Sequencer: IDLE/SHIFT control, beat/divider counting and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      shift_r   <= '0;
      order_r   <= 1'b0;
      beat_r    <= '0;
      div_r     <= 8'd0;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else if (abort) begin
      state_r   <= IDLE;
      beat_r    <= '0;
      div_r     <= 8'd0;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else if (accept_s) begin
      state_r   <= SHIFT;
      shift_r   <= word_in;
      order_r   <= msb_first;
      beat_r    <= '0;
      div_r     <= 8'd0;
      ser_bit   <= first_bit(word_in, msb_first);
      ser_valid <= 1'b1;
      ser_first <= 1'b1;
      ser_last  <= 1'b0;
      busy      <= 1'b1;
    end else if (state_r == SHIFT) begin
      if (!beat_end_s) begin
        div_r <= div_r + 8'd1;
      end else if (beat_r == LAST_BEAT) begin
        state_r   <= IDLE;
        beat_r    <= '0;
        div_r     <= 8'd0;
        ser_bit   <= 1'b0;
        ser_valid <= 1'b0;
        ser_first <= 1'b0;
        ser_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        // Shift towards the output end so the next beat's bit sits at index 1
        // (LSB first) or WORD_WIDTH-2 (MSB first) of the current contents.
        div_r     <= 8'd0;
        beat_r    <= beat_r + {{(BEAT_W-1){1'b0}}, 1'b1};
        ser_first <= 1'b0;
        ser_last  <= (beat_r == PENULT_BEAT);
        if (order_r) begin
          shift_r <= {shift_r[WORD_WIDTH-2:0], 1'b0};
          ser_bit <= shift_r[WORD_WIDTH-2];
        end else begin
          shift_r <= {1'b0, shift_r[WORD_WIDTH-1:1]};
          ser_bit <= shift_r[1];
        end
      end
    end else begin
      state_r <= IDLE;
    end
  end

endmodule

// File: tb/tb_word_serialiser.sv
// Self-checking bench for word_serialiser: expected beat streams come from a
// per-cycle queue built directly from the word bits, order and beat length.
module tb_word_serialiser;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n     = 1'b0;
  logic         word_valid  = 1'b0;
  logic         word_valid3 = 1'b0;
  logic         msb_first   = 1'b0;
  logic         abort       = 1'b0;
  logic [W-1:0] word_in     = '0;

  logic word_ready,  ser_bit,  ser_valid,  ser_first,  ser_last,  busy;
  logic word_ready3, ser_bit3, ser_valid3, ser_first3, ser_last3, busy3;

  int checks = 0;
  int errors = 0;

  // Expected per-cycle outputs {busy, ser_valid, ser_bit, ser_first, ser_last}
  logic [4:0] exp_q[$];

  word_serialiser #(.WORD_WIDTH(W), .BEAT_DIV(1)) dut (
    .clk(clk), .reset_n(reset_n), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .msb_first(msb_first), .abort(abort),
    .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_first(ser_first),
    .ser_last(ser_last), .busy(busy)
  );

  word_serialiser #(.WORD_WIDTH(W), .BEAT_DIV(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .word_in(word_in), .word_valid(word_valid3),
    .word_ready(word_ready3), .msb_first(msb_first), .abort(abort),
    .ser_bit(ser_bit3), .ser_valid(ser_valid3), .ser_first(ser_first3),
    .ser_last(ser_last3), .busy(busy3)
  );

  function automatic void model_word(input logic [W-1:0] w, input logic msb, input int div);
    logic b;
    for (int k = 0; k < W; k++) begin
      b = msb ? w[W-1-k] : w[k];
      for (int d = 0; d < div; d++) exp_q.push_back({2'b11, b, (k == 0), (k == W - 1)});
    end
  endfunction

  function automatic logic [4:0] model_next();
    if (exp_q.size() == 0) return 5'b00000;
    return exp_q.pop_front();
  endfunction

  function automatic logic [4:0] outs1();
    return {busy, ser_valid, ser_bit, ser_first, ser_last};
  endfunction

  function automatic logic [4:0] outs3();
    return {busy3, ser_valid3, ser_bit3, ser_first3, ser_last3};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    word_valid = 1'b1;
    reset_n    = 1'b0;
    repeat (2) tick();
    checks++; if (outs1() !== 5'b0) begin errors++; $display("FAIL reset_outs obs %b exp 00000", outs1()); end
    checks++; if (outs3() !== 5'b0) begin errors++; $display("FAIL reset_outs3 obs %b exp 00000", outs3()); end
    checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL reset_ready obs %b exp 0", word_ready); end
    word_valid = 1'b0;
    reset_n    = 1'b1;
    #1;
    checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready obs %b exp 1", word_ready); end
    tick();
    checks++; if (outs1() !== 5'b0) begin errors++; $display("FAIL reset_idle obs %b exp 00000", outs1()); end
  endtask

  task automatic test_lsb_first();
    logic [4:0] e;
    logic       er;
    word_in = 32'h0000_0001; msb_first = 1'b0; word_valid = 1'b1;
    #1;
    checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL lsb_ready obs %b exp 1", word_ready); end
    model_word(word_in, 1'b0, 1);
    tick();
    word_valid = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      e = model_next();
      checks++; if (outs1() !== e) begin errors++; $display("FAIL lsb_stream cyc %0d obs %b exp %b", c, outs1(), e); end
      er = (exp_q.size() == 0);
      checks++; if (word_ready !== er) begin errors++; $display("FAIL lsb_ready cyc %0d obs %b exp %b", c, word_ready, er); end
      tick();
    end
  endtask

  task automatic test_msb_first();
    logic [4:0]   e;
    logic [W-1:0] words [2];
    words[0] = 32'h8000_0000;
    words[1] = 32'h0000_0001;
    for (int n = 0; n < 2; n++) begin
      word_in = words[n]; msb_first = 1'b1; word_valid = 1'b1;
      #1;
      model_word(word_in, 1'b1, 1);
      tick();
      word_valid = 1'b0; msb_first = 1'b0; word_in = '1;
      for (int c = 1; c <= 33; c++) begin
        e = model_next();
        checks++; if (outs1() !== e) begin errors++; $display("FAIL msb_stream w%0d cyc %0d obs %b exp %b", n, c, outs1(), e); end
        tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    logic       er;
    int         acc_cyc;
    acc_cyc = -1;
    word_in = 32'hA5A5_A5A5; msb_first = 1'b0; word_valid = 1'b1;
    #1;
    model_word(word_in, 1'b0, 1);
    tick();
    word_in = 32'h0F0F_0F0F;
    for (int c = 1; c <= 65; c++) begin
      e = model_next();
      checks++; if (outs1() !== e) begin errors++; $display("FAIL b2b_stream cyc %0d obs %b exp %b", c, outs1(), e); end
      er = (exp_q.size() == 0);
      checks++; if (word_ready !== er) begin errors++; $display("FAIL b2b_ready cyc %0d obs %b exp %b", c, word_ready, er); end
      if (word_valid && er) begin
        model_word(word_in, 1'b0, 1);
        acc_cyc = c;
      end
      tick();
      if (acc_cyc >= 0) word_valid = 1'b0;
    end
    checks++; if (acc_cyc != 32) begin errors++; $display("FAIL b2b_accept_cycle obs %0d exp 32", acc_cyc); end
  endtask

  task automatic test_divider();
    logic [4:0] e;
    logic       er;
    word_in = 32'h0000_0006; msb_first = 1'b0; word_valid3 = 1'b1;
    #1;
    checks++; if (word_ready3 !== 1'b1) begin errors++; $display("FAIL div_ready obs %b exp 1", word_ready3); end
    model_word(word_in, 1'b0, 3);
    tick();
    word_valid3 = 1'b0;
    for (int c = 1; c <= 97; c++) begin
      e = model_next();
      checks++; if (outs3() !== e) begin errors++; $display("FAIL div_stream cyc %0d obs %b exp %b", c, outs3(), e); end
      er = (exp_q.size() == 0);
      checks++; if (word_ready3 !== er) begin errors++; $display("FAIL div_ready cyc %0d obs %b exp %b", c, word_ready3, er); end
      tick();
    end
  endtask

  task automatic test_abort();
    logic [4:0] e;
    // Abort while idle changes nothing but blocks ready.
    abort = 1'b1;
    #1;
    checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL abort_idle_ready obs %b exp 0", word_ready); end
    tick();
    abort = 1'b0;
    checks++; if (outs1() !== 5'b0) begin errors++; $display("FAIL abort_idle_outs obs %b exp 00000", outs1()); end
    word_in = $urandom(); msb_first = 1'($urandom_range(0, 1)); word_valid = 1'b1;
    #1;
    model_word(word_in, msb_first, 1);
    tick();
    word_valid = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      e = model_next();
      checks++; if (outs1() !== e) begin errors++; $display("FAIL abort_pre cyc %0d obs %b exp %b", c, outs1(), e); end
      if (c < 11) tick();
    end
    abort = 1'b1; word_valid = 1'b1; word_in = 32'hFFFF_FFFF; msb_first = 1'b0;
    #1;
    checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL abort_ready obs %b exp 0", word_ready); end
    exp_q.delete();
    tick();
    e = model_next();
    checks++; if (outs1() !== e) begin errors++; $display("FAIL abort_outs obs %b exp %b", outs1(), e); end
    abort = 1'b0;
    #1;
    checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL abort_drop_ready obs %b exp 1", word_ready); end
    model_word(word_in, 1'b0, 1);
    tick();
    word_valid = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      e = model_next();
      checks++; if (outs1() !== e) begin errors++; $display("FAIL abort_post cyc %0d obs %b exp %b", c, outs1(), e); end
      tick();
    end
  endtask

  task automatic test_reset_mid_word();
    logic [4:0] e;
    word_in = 32'hFFFF_FFFF; msb_first = 1'b0; word_valid = 1'b1;
    #1;
    model_word(word_in, 1'b0, 1);
    tick();
    word_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      e = model_next();
      checks++; if (outs1() !== e) begin errors++; $display("FAIL rst_pre cyc %0d obs %b exp %b", c, outs1(), e); end
      if (c < 6) tick();
    end
    reset_n = 1'b0; word_valid = 1'b1;
    #1;
    checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready obs %b exp 0", word_ready); end
    exp_q.delete();
    tick();
    checks++; if (outs1() !== 5'b0) begin errors++; $display("FAIL rst_mid_outs obs %b exp 00000", outs1()); end
    checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready2 obs %b exp 0", word_ready); end
    reset_n = 1'b1; word_in = 32'h1234_5678; msb_first = 1'b0;
    #1;
    checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready obs %b exp 1", word_ready); end
    model_word(word_in, 1'b0, 1);
    tick();
    word_valid = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      e = model_next();
      checks++; if (outs1() !== e) begin errors++; $display("FAIL rst_post cyc %0d obs %b exp %b", c, outs1(), e); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [4:0] e;
    logic       er;
    for (int c = 0; c < 400; c++) begin
      e = model_next();
      checks++; if (outs1() !== e) begin errors++; $display("FAIL rand_stream cyc %0d obs %b exp %b", c, outs1(), e); end
      abort      = ($urandom_range(0, 63) == 0);
      word_valid = ($urandom_range(0, 3) != 0);
      word_in    = $urandom();
      msb_first  = 1'($urandom_range(0, 1));
      #1;
      er = !abort && (exp_q.size() == 0);
      checks++; if (word_ready !== er) begin errors++; $display("FAIL rand_ready cyc %0d obs %b exp %b", c, word_ready, er); end
      if (abort) exp_q.delete();
      else if (word_valid && er) model_word(word_in, msb_first, 1);
      tick();
    end
    abort = 1'b0; word_valid = 1'b0;
    for (int c = 0; c < 34; c++) begin
      e = model_next();
      checks++; if (outs1() !== e) begin errors++; $display("FAIL rand_drain cyc %0d obs %b exp %b", c, outs1(), e); end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_divider();
    test_abort();
    test_reset_mid_word();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
